// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe scroller: default geometry and
// the rotation used to present pipe X values relative to the in-scope pipe.
package pipe_pkg;

  localparam int DEF_N_PIPES      = 4;
  localparam int DEF_XW           = 10;
  localparam int DEF_X_SPAN       = 640;
  localparam int DEF_PIPE_SPACING = 160;
  localparam int DEF_SCOPE_X      = 240;
  localparam int DEF_SPEED_W      = 3;
  localparam int DEF_SCORE_W      = 8;

  // Pipe index shown in x_rel slot k when pipe 'base' is in scope.
  function automatic int unsigned slot_index(input int unsigned base,
                                             input int unsigned k,
                                             input int unsigned n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Control/status bundle of the pipe scroller: scroll controls in, pipe
// positions, scope index and scoring out.
interface pipe_scroller_if
  import pipe_pkg::*;
#(
  parameter int N_PIPES = DEF_N_PIPES,
  parameter int XW      = DEF_XW,
  parameter int SPEED_W = DEF_SPEED_W,
  parameter int SCORE_W = DEF_SCORE_W
);
  localparam int OPW = $clog2(N_PIPES);

  logic                    count_EN;
  logic [SPEED_W-1:0]      speed;
  logic                    Lose;
  logic [OPW-1:0]          out_pipe;
  logic [N_PIPES*XW-1:0]   x_rel;
  logic [SCORE_W-1:0]      Score;
  logic                    score_sat;
  logic                    pass_pulse;
  logic                    lost;

  modport master (
    output count_EN, speed, Lose,
    input  out_pipe, x_rel, Score, score_sat, pass_pulse, lost
  );

  modport slave (
    input  count_EN, speed, Lose,
    output out_pipe, x_rel, Score, score_sat, pass_pulse, lost
  );

endinterface

// File: rtl/pipe_x_cell.sv
// One pipe X register that moves left by 'speed' per enabled step and
// wraps by X_SPAN so the spacing between pipes is preserved.
module pipe_x_cell #(
  parameter int XW      = 10,
  parameter int X_SPAN  = 640,
  parameter int SPEED_W = 3,
  parameter int RST_X   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic [SPEED_W-1:0] speed,
  output logic [XW-1:0]      x
);

  logic [XW:0]   x_ext;
  logic [XW:0]   s_ext;
  logic [XW-1:0] nxt;

  // One extra bit keeps x + X_SPAN from overflowing before the subtract.
  always_comb begin
    x_ext = {1'b0, x};
    s_ext = (XW+1)'(speed);
    if (x_ext >= s_ext)
      nxt = XW'(x_ext - s_ext);
    else
      nxt = XW'(x_ext + (XW+1)'(X_SPAN) - s_ext);
  end

  always_ff @(posedge clk) begin
    if (reset)
      x <= XW'(RST_X);
    else if (step)
      x <= nxt;
  end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls N_PIPES evenly spaced pipes, tracks which pipe is in the bird's
// scope, and scores each pipe passed until a loss is flagged.
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int N_PIPES      = DEF_N_PIPES,
  parameter int XW           = DEF_XW,
  parameter int X_SPAN       = DEF_X_SPAN,
  parameter int PIPE_SPACING = DEF_PIPE_SPACING,
  parameter int SCOPE_X      = DEF_SCOPE_X,
  parameter int SPEED_W      = DEF_SPEED_W,
  parameter int SCORE_W      = DEF_SCORE_W
) (
  input  logic             clk,
  input  logic             reset,
  pipe_scroller_if.slave   bus
);

  localparam int OPW = $clog2(N_PIPES);

  logic [XW-1:0]         x_all [N_PIPES];
  logic [OPW-1:0]        out_pipe_q;
  logic [SCORE_W-1:0]    score_q;
  logic                  pass_q;
  logic                  lost_q;
  logic                  advance;
  logic [N_PIPES*XW-1:0] x_rel_c;

  for (genvar i = 0; i < N_PIPES; i++) begin : g_pipe
    pipe_x_cell #(
      .XW      (XW),
      .X_SPAN  (X_SPAN),
      .SPEED_W (SPEED_W),
      .RST_X   (i * PIPE_SPACING)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .step  (bus.count_EN),
      .speed (bus.speed),
      .x     (x_all[i])
    );
  end

  // Scope test looks at the pre-step X of the in-scope pipe.
  always_comb begin
    advance = bus.count_EN && (x_all[out_pipe_q] < XW'(SCOPE_X));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pipe_q <= OPW'(N_PIPES / 2);
      score_q    <= '0;
      pass_q     <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      pass_q <= advance;
      lost_q <= lost_q | bus.Lose;
      if (advance) begin
        out_pipe_q <= (out_pipe_q == OPW'(N_PIPES - 1)) ? '0 : out_pipe_q + OPW'(1);
        if (!lost_q && !bus.Lose && (score_q != '1))
          score_q <= score_q + SCORE_W'(1);
      end
    end
  end

  always_comb begin
    x_rel_c = '0;
    for (int unsigned k = 0; k < N_PIPES; k++)
      x_rel_c[k*XW +: XW] = x_all[OPW'(slot_index(32'(out_pipe_q), k, N_PIPES))];
  end

  assign bus.out_pipe   = out_pipe_q;
  assign bus.x_rel      = x_rel_c;
  assign bus.Score      = score_q;
  assign bus.score_sat  = (score_q == '1);
  assign bus.pass_pulse = pass_q;
  assign bus.lost       = lost_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: reset, stepping, scope advance, wrap,
// loss freeze, mid-scroll reset and score saturation on a narrow score.
module tb_pipe_scroller;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_scroller_if #(.N_PIPES(4), .XW(10), .SPEED_W(3), .SCORE_W(8)) pif ();
  pipe_scroller_if #(.N_PIPES(4), .XW(10), .SPEED_W(3), .SCORE_W(2)) pif2 ();

  pipe_scroller #(
    .N_PIPES(4), .XW(10), .X_SPAN(640), .PIPE_SPACING(160),
    .SCOPE_X(240), .SPEED_W(3), .SCORE_W(8)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (pif.slave)
  );

  pipe_scroller #(
    .N_PIPES(4), .XW(10), .X_SPAN(640), .PIPE_SPACING(160),
    .SCOPE_X(240), .SPEED_W(3), .SCORE_W(2)
  ) dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (pif2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_slots(input string tag, input int e0, input int e1,
                           input int e2, input int e3);
    chk({tag, ".s0"}, 32'(pif.x_rel[0 +: 10]),  e0);
    chk({tag, ".s1"}, 32'(pif.x_rel[10 +: 10]), e1);
    chk({tag, ".s2"}, 32'(pif.x_rel[20 +: 10]), e2);
    chk({tag, ".s3"}, 32'(pif.x_rel[30 +: 10]), e3);
  endtask

  task automatic chk_reset(input string tag);
    chk_slots(tag, 320, 480, 0, 160);
    chk({tag, ".out"},  32'(pif.out_pipe), 2);
    chk({tag, ".score"}, 32'(pif.Score), 0);
    chk({tag, ".sat"},  32'(pif.score_sat), 0);
    chk({tag, ".pass"}, 32'(pif.pass_pulse), 0);
    chk({tag, ".lost"}, 32'(pif.lost), 0);
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    pif.count_EN = 1'b0;  pif.speed = 3'd0;  pif.Lose = 1'b0;
    pif2.count_EN = 1'b0; pif2.speed = 3'd0; pif2.Lose = 1'b0;

    tick(1);
    chk_reset("rst");

    // Speed 1: pipe2 reaches 239 after 81 steps, advances on step 82
    rst = 1'b0; pif.count_EN = 1'b1; pif.speed = 3'd1;
    tick(81);
    chk("e81.x", 32'(pif.x_rel[0 +: 10]), 239);
    chk("e81.out", 32'(pif.out_pipe), 2);
    chk("e81.pass", 32'(pif.pass_pulse), 0);
    chk("e81.score", 32'(pif.Score), 0);
    tick(1);
    chk("e82.out", 32'(pif.out_pipe), 3);
    chk("e82.score", 32'(pif.Score), 1);
    chk("e82.pass", 32'(pif.pass_pulse), 1);
    chk("e82.s0", 32'(pif.x_rel[0 +: 10]), 398);
    chk("e82.s3", 32'(pif.x_rel[30 +: 10]), 238);
    tick(1);
    chk("e83.pass", 32'(pif.pass_pulse), 0);
    chk("e83.score", 32'(pif.Score), 1);

    // Hold via count_EN=0, then via speed=0
    pif.count_EN = 1'b0;
    tick(5);
    chk("hold_en.s0", 32'(pif.x_rel[0 +: 10]), 397);
    chk("hold_en.out", 32'(pif.out_pipe), 3);
    pif.count_EN = 1'b1; pif.speed = 3'd0;
    tick(3);
    chk("hold_spd.s0", 32'(pif.x_rel[0 +: 10]), 397);

    // Loss on the advance cycle
    pif.speed = 3'd1;
    tick(158);
    chk("prelose.s0", 32'(pif.x_rel[0 +: 10]), 239);
    chk("prelose.lost", 32'(pif.lost), 0);
    pif.Lose = 1'b1;
    tick(1);
    chk("lose.out", 32'(pif.out_pipe), 0);
    chk("lose.score", 32'(pif.Score), 1);
    chk("lose.lost", 32'(pif.lost), 1);
    chk("lose.pass", 32'(pif.pass_pulse), 1);
    chk("lose.s0", 32'(pif.x_rel[0 +: 10]), 398);
    chk("lose.s3", 32'(pif.x_rel[30 +: 10]), 238);
    pif.Lose = 1'b0;
    tick(160);
    chk("frozen.out", 32'(pif.out_pipe), 1);
    chk("frozen.score", 32'(pif.Score), 1);
    chk("frozen.lost", 32'(pif.lost), 1);
    chk("frozen.pass", 32'(pif.pass_pulse), 1);

    // Mid-scroll reset overrides count_EN and Lose
    pif.speed = 3'd5; pif.Lose = 1'b1; rst = 1'b1;
    tick(1);
    chk_reset("midrst");

    // First step right after release; pipe0 wraps 0 -> 637
    rst = 1'b0; pif.Lose = 1'b0; pif.speed = 3'd3;
    tick(1);
    chk_slots("wrap0", 317, 477, 637, 157);
    chk("wrap0.out", 32'(pif.out_pipe), 2);
    chk("wrap0.lost", 32'(pif.lost), 0);

    // 127 steps of 5: advances at steps 17, 49, 81, 113
    pif.speed = 3'd5;
    tick(127);
    chk_slots("run5", 322, 482, 2, 162);
    chk("run5.out", 32'(pif.out_pipe), 2);
    chk("run5.score", 32'(pif.Score), 4);
    chk("run5.pass", 32'(pif.pass_pulse), 0);

    // pipe0 at 2 with speed 3 wraps to 639
    pif.speed = 3'd3;
    tick(1);
    chk_slots("wrap2", 319, 479, 639, 159);
    chk("wrap2.out", 32'(pif.out_pipe), 2);

    // Two-bit score saturates after the third advance
    pif.count_EN = 1'b0;
    rst2 = 1'b0; pif2.count_EN = 1'b1; pif2.speed = 3'd1;
    tick(82);
    chk("sat1.score", 32'(pif2.Score), 1);
    chk("sat1.sat", 32'(pif2.score_sat), 0);
    chk("sat1.out", 32'(pif2.out_pipe), 3);
    tick(160);
    chk("sat2.score", 32'(pif2.Score), 2);
    chk("sat2.sat", 32'(pif2.score_sat), 0);
    tick(160);
    chk("sat3.score", 32'(pif2.Score), 3);
    chk("sat3.sat", 32'(pif2.score_sat), 1);
    tick(160);
    chk("sat4.score", 32'(pif2.Score), 3);
    chk("sat4.sat", 32'(pif2.score_sat), 1);
    chk("sat4.pass", 32'(pif2.pass_pulse), 1);
    chk("sat4.out", 32'(pif2.out_pipe), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_scroller.md
PIPE_SCROLLER -- requirements
Module: pipe_scroller

Interface
REQ-001 Parameter N_PIPES, default 4: number of scrolling pipes, 2..16.
REQ-002 Parameter XW, default 10: X coordinate width, bits.
REQ-003 Parameter X_SPAN, default 640: wrap distance; < 2**XW.
REQ-004 Parameter PIPE_SPACING, default 160: reset gap between adjacent pipes; N_PIPES*PIPE_SPACING = X_SPAN.
REQ-005 Parameter SCOPE_X, default 240: scope threshold for the bird (pipe left edge).
REQ-006 Parameter SPEED_W, default 3: speed input width.
REQ-007 Parameter SCORE_W, default 8: score width.
REQ-008 clk  in  1  single clock; all state changes on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 count_EN  in  1  scroll step enable, one step per cycle high.
REQ-011 speed  in  SPEED_W  pixels moved per step; 0 = hold.
REQ-012 Lose  in  1  loss indication from obstacle logic.
REQ-013 out_pipe  out  clog2(N_PIPES)  index of pipe currently in scope.
REQ-014 x_rel  out  N_PIPES*XW  slot k (bits k*XW+:XW) = X of pipe (out_pipe+k) mod N_PIPES.
REQ-015 Score  out  SCORE_W  pipes passed.
REQ-016 score_sat  out  1  Score has reached all-ones.
REQ-017 pass_pulse  out  1  one-cycle strobe per scope advance.
REQ-018 lost  out  1  sticky loss flag.

Function
REQ-019 On a cycle with count_EN=1 and speed=s, each pipe x SHALL become x-s if x>=s, else x+X_SPAN-s (spacing preserved across wrap).
REQ-020 count_EN=0 or s=0 SHALL leave all pipe X values unchanged.
REQ-021 Scope test SHALL use the pre-update value: if count_EN=1 and x[out_pipe] < SCOPE_X, out_pipe SHALL advance by 1 modulo N_PIPES in the same edge.
REQ-022 At most one scope advance SHALL occur per cycle.
REQ-023 pass_pulse SHALL be high for exactly the cycle after each advance edge (registered), otherwise low.
REQ-024 On an advance with lost=0 (pre-update) and Lose=0, Score SHALL increment by 1, saturating at 2**SCORE_W-1; score_sat = (Score == all-ones).
REQ-025 lost SHALL set on any cycle Lose=1 and hold until reset; while lost=1 Score SHALL freeze; scrolling continues under count_EN.
REQ-026 Lose and an advance in the same cycle: advance and pass_pulse occur, Score does not increment.
REQ-027 x_rel, out_pipe SHALL be combinational from registers (zero latency, no input-to-output comb path).
REQ-028 Arithmetic SHALL be unsigned XW+1 bits internally; X values always in [0, X_SPAN-1].

Reset
REQ-029 While reset=1 (any cycle, including mid-scroll), pipe i X SHALL load i*PIPE_SPACING, out_pipe = N_PIPES/2, Score=0, score_sat=0, pass_pulse=0, lost=0; reset overrides count_EN and Lose.
REQ-030 First step SHALL occur on the first edge after reset deasserts with count_EN=1.

Structure
REQ-031 Shared package pipe_pkg SHALL hold default widths, X_SPAN, PIPE_SPACING, SCOPE_X constants and the x_rel slot-indexing function.
REQ-032 One sub-module pipe_x_cell (one register, decrement-with-wrap, reset-value parameter) SHALL be instantiated N_PIPES times.

Verification
REQ-033 Defaults, reset, 1 cycle: X = {0,160,320,480}, out_pipe=2, x_rel slot0=320, Score=0.
REQ-034 speed=1, count_EN=1 for 81 cycles after reset: pipe2 X=239 after edge 81, out_pipe=3 and Score=1 at edge 82, pass_pulse high one cycle.
REQ-035 Wrap: pipe0 X=0, speed=3, one step -> X=637; X=2, speed=3 -> 639; spacing to pipe1 stays 160 mod 640.
REQ-036 Lose=1 on the cycle of an advance: out_pipe advances, Score unchanged, lost=1; later advances keep Score frozen.
REQ-037 SCORE_W=2, force 4 advances: Score 1,2,3,3; score_sat=1 after third.
REQ-038 reset asserted mid-scroll with count_EN=1, speed=5: next edge all registers at reset values.
